// File: rtl/adc_ram_reader.sv
// -----------------------------------------------------------------------------
// adc_ram_reader
//
// Reads one completed half of a ping-pong dual-port block RAM and streams its
// words out over a ready/valid interface. The writer side signals which half it
// is filling through i_wr_ram_2_flag; each toggle of that flag means the other
// half has just been filled and may be read out.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_en                  readout enable (checked only when idle)
//   i_wr_ram_2_flag       writer is in the upper half
//   o_rd_ram_addr/_en     RAM read port (data returns one cycle later)
//   i_rd_ram_data         RAM read data
//   o_m_data/_valid/_last output stream, i_m_ready is the sink's ready
//   o_block_done          one-cycle pulse after the last word of a half
//   o_overrun             sticky: a half completed before the previous one was
//                         taken; cleared by i_overrun_clr
//   o_rd_half             half currently being read (0 lower, 1 upper)
//   o_debug_state         current FSM state
// -----------------------------------------------------------------------------
module adc_ram_reader #(
    parameter int RAM_DEPTH  = 2048,
    parameter int DATA_WIDTH = 48
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_wr_ram_2_flag,
    output logic [14:0]           o_rd_ram_addr,
    output logic                  o_rd_ram_en,
    input  logic [DATA_WIDTH-1:0] i_rd_ram_data,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_valid,
    output logic                  o_m_last,
    input  logic                  i_m_ready,
    output logic                  o_block_done,
    output logic                  o_overrun,
    input  logic                  i_overrun_clr,
    output logic                  o_rd_half,
    output logic [2:0]            o_debug_state
);

    localparam int HALF  = RAM_DEPTH / 2;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [14:0]      HALF_BASE = 15'(HALF);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(HALF - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                state_q,      state_d;
    logic                  flag_q,       flag_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_half_q,  pend_half_d;
    logic                  overrun_q,    overrun_d;
    logic                  rd_half_q,    rd_half_d;
    logic [IDX_W-1:0]      index_q,      index_d;
    logic [14:0]           addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] m_data_q,     m_data_d;
    logic                  m_last_q,     m_last_d;

    logic comp_evt;
    logic comp_half;
    logic rd_en;
    logic m_valid;
    logic block_done;

    function automatic logic [14:0] word_addr(input logic half, input logic [IDX_W-1:0] idx);
        return (half ? HALF_BASE : 15'd0) + 15'(idx);
    endfunction

    // Any flag toggle completes a half. The half just completed is the one the
    // writer was in before the toggle, i.e. the registered flag value.
    assign comp_evt  = flag_q ^ i_wr_ram_2_flag;
    assign comp_half = flag_q;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        flag_d       = i_wr_ram_2_flag;
        pend_valid_d = pend_valid_q;
        pend_half_d  = pend_half_q;
        overrun_d    = overrun_q;
        rd_half_d    = rd_half_q;
        index_d      = index_q;
        addr_d       = addr_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        rd_en        = 1'b0;
        m_valid      = 1'b0;
        block_done   = 1'b0;

        // Latest completion always overwrites the pending request.
        if (comp_evt) begin
            pend_valid_d = 1'b1;
            pend_half_d  = comp_half;
        end

        // Set is evaluated after clear so a coincident event wins.
        if (i_overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (comp_evt && (state_q != ST_IDLE || pend_valid_q)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!i_en) begin
                    // Disabled: completions are discarded, not queued.
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    state_d      = ST_FETCH;
                    rd_half_d    = pend_half_q;
                    index_d      = '0;
                    addr_d       = word_addr(pend_half_q, '0);
                    pend_valid_d = comp_evt;
                end
            end
            ST_FETCH: begin
                rd_en   = 1'b1;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                m_data_d = i_rd_ram_data;
                m_last_d = (index_q == LAST_IDX);
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                m_valid = 1'b1;
                if (i_m_ready) begin
                    if (m_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        addr_d  = word_addr(rd_half_q, index_q + 1'b1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                block_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            flag_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_half_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rd_half_q    <= 1'b0;
            index_q      <= '0;
            addr_q       <= '0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            flag_q       <= flag_d;
            pend_valid_q <= pend_valid_d;
            pend_half_q  <= pend_half_d;
            overrun_q    <= overrun_d;
            rd_half_q    <= rd_half_d;
            index_q      <= index_d;
            addr_q       <= addr_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
        end
    end

    // Strobes decode straight from the state register, so an asynchronous
    // reset drops o_m_valid without waiting for a clock.
    assign o_rd_ram_addr = addr_q;
    assign o_rd_ram_en   = rd_en;
    assign o_m_data      = m_data_q;
    assign o_m_valid     = m_valid;
    assign o_m_last      = m_last_q;
    assign o_block_done  = block_done;
    assign o_overrun     = overrun_q;
    assign o_rd_half     = rd_half_q;
    assign o_debug_state = state_q;

endmodule

// File: doc/adc_ram_reader.md
ADC_RAM_READER -- requirements
Module: adc_ram_reader

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 2048, total DPBRAM words; even, 4..32768.
REQ-002 SHALL have parameter DATA_WIDTH, default 48, RAM word width (V and C 24-bit samples packed).
REQ-003 SHALL have port i_clk  in  1  single clock for all logic.
REQ-004 SHALL have port i_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_en  in  1  readout enable.
REQ-006 SHALL have port i_wr_ram_2_flag  in  1  writer address is in upper half (addr >= RAM_DEPTH/2).
REQ-007 SHALL have port o_rd_ram_addr  out  15  DPBRAM read address.
REQ-008 SHALL have port o_rd_ram_en  out  1  DPBRAM read enable; data valid on i_rd_ram_data 1 cycle later.
REQ-009 SHALL have port i_rd_ram_data  in  DATA_WIDTH  DPBRAM read data.
REQ-010 SHALL have ports o_m_data  out  DATA_WIDTH, o_m_valid  out  1, o_m_last  out  1, i_m_ready  in  1: output stream.
REQ-011 SHALL have port o_block_done  out  1  one-cycle pulse per completed half.
REQ-012 SHALL have ports o_overrun  out  1 (sticky) and i_overrun_clr  in  1.
REQ-013 SHALL have port o_rd_half  out  1  half being read (0 lower, 1 upper).
REQ-014 SHALL have port o_debug_state  out  3  current FSM state.

Function
REQ-015 SHALL register i_wr_ram_2_flag each cycle; rising edge = lower half complete, falling edge = upper half complete ("completion event").
REQ-016 SHALL hold one pending request (pend_valid, pend_half); a completion event sets pend_valid=1, pend_half = completed half; latest event wins.
REQ-017 SHALL set o_overrun when a completion event occurs while state != IDLE, or while pend_valid=1; cleared only by i_overrun_clr or reset; set wins over simultaneous clear.
REQ-018 SHALL use states IDLE=0, FETCH=1, CAPTURE=2, SEND=3, DONE=4.
REQ-019 IDLE: if i_en & pend_valid -> FETCH; load o_rd_half=pend_half, index=0, clear pend_valid (same-cycle new event re-sets it).
REQ-020 IDLE with i_en=0: pend_valid SHALL be cleared; no readout starts.
REQ-021 FETCH: o_rd_ram_en=1 for exactly one cycle, o_rd_ram_addr = o_rd_half*(RAM_DEPTH/2) + index; -> CAPTURE.
REQ-022 CAPTURE: o_m_data <= i_rd_ram_data at cycle end; o_m_last <= (index == RAM_DEPTH/2-1); -> SEND.
REQ-023 SEND: o_m_valid=1, o_m_data/o_m_last stable until i_m_ready=1; on handshake, if last -> DONE else index+1 -> FETCH.
REQ-024 o_m_valid SHALL be asserted only in SEND; minimum 3 cycles per word.
REQ-025 DONE: o_block_done=1 for one cycle; -> IDLE.
REQ-026 i_en deassertion during FETCH/CAPTURE/SEND SHALL NOT abort; current block completes.
REQ-027 o_rd_ram_en SHALL be 0 outside FETCH; o_rd_ram_addr holds last value outside FETCH.
REQ-028 Undefined state encodings SHALL go to IDLE next cycle.

Reset
REQ-029 On i_rst=0: state=IDLE, o_rd_ram_addr=0, o_rd_ram_en=0, o_m_data=0, o_m_valid=0, o_m_last=0, o_block_done=0, o_overrun=0, o_rd_half=0, pend_valid=0, index=0, edge register=0.
REQ-030 Reset mid-block SHALL drop o_m_valid immediately; after release, no readout until a new completion event.

Verification (RAM_DEPTH=8, RAM model latency 1, data = address)
REQ-031 i_en=1, ready=1, ram_2_flag 0->1 -> 4 words 0,1,2,3 on stream, o_m_last on word 3, o_block_done 1 cycle, o_rd_half=0.
REQ-032 Then ram_2_flag 1->0 -> words 4,5,6,7, o_rd_half=1, o_overrun=0.
REQ-033 i_m_ready held 0 for 10 cycles in SEND -> o_m_valid=1, o_m_data unchanged, no address advance; resumes on ready=1.
REQ-034 Completion event during SEND -> o_overrun=1, next block starts from IDLE right after DONE; i_overrun_clr pulse -> o_overrun=0.
REQ-035 i_en=0 when event arrives, then i_en=1 -> no readout; i_en=0 during block 1 -> block finishes with all 4 words.
REQ-036 i_rst=0 while o_m_valid=1 -> all outputs 0 next cycle; o_debug_state=0.
